// File: rtl/gmii_rx_pkg.sv
// Shared constants and state type for the GMII receive framer.
// Bytes are 8-bit GMII octets; CRC constants use the reflected form.
package gmii_rx_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // FCS is 4 bytes, so holding 5 exposes the last data byte at EOF
  localparam int DLY_DEPTH = 5;

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    PREAMBLE,
    PAYLOAD
  } rx_state_e;

endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive byte bus and the framed per-byte output stream.
// The stream has no ready: it always runs at line rate.
interface gmii_rx_if;

  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;

  modport master (
    output gmii_rxd,
    output gmii_rx_dv,
    output gmii_rx_er
  );

  modport slave (
    input gmii_rxd,
    input gmii_rx_dv,
    input gmii_rx_er
  );

endinterface

interface gmii_rx_stream_if;

  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tuser;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    output m_tuser
  );

  modport slave (
    input m_tdata,
    input m_tvalid,
    input m_tlast,
    input m_tuser
  );

endinterface

// File: rtl/gmii_rx_framer_crc32_d8.sv
// Combinational CRC-32 update, one byte per call, LSB first.
// Register is kept uncomplemented; a good frame leaves the residue.
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, flags bad frames.
// Define GMII_RX_FRAMER_STATS_EN to build the good/bad frame counters.
module gmii_rx_framer
  import gmii_rx_pkg::*;
#(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64,
  parameter int MAX_PRE = 7
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  gmii_rx_if.slave         gmii,
  gmii_rx_stream_if.master m,
  output logic [31:0]      stat_ok,
  output logic [31:0]      stat_bad
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam int PW = $clog2(MAX_PRE + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] pre_t;
  typedef logic [DLY_DEPTH-1:0][7:0] dly_t;

  localparam cnt_t LEN_MAX = cnt_t'(MAX_LEN);
  localparam cnt_t LEN_MIN = cnt_t'(MIN_LEN);
  localparam cnt_t LEN_DLY = cnt_t'(DLY_DEPTH);
  localparam pre_t PRE_MAX = pre_t'(MAX_PRE);

  logic [7:0] rxd;
  logic       dv;
  logic       er;

  assign rxd = gmii.gmii_rxd;
  assign dv  = gmii.gmii_rx_dv;
  assign er  = gmii.gmii_rx_er;

  rx_state_e   state_q, state_d;
  pre_t        pre_cnt_q, pre_cnt_d;
  logic [31:0] crc_q, crc_d, crc_nxt;
  cnt_t        cnt_q, cnt_d;
  logic        err_q, err_d;
  dly_t        dly_q, dly_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;

  logic       is_pre;
  logic       is_sfd;
  logic       full;
  logic       bad_eof;
  logic [7:0] oldest;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (rxd),
    .crc_out (crc_nxt)
  );

  // an errored byte never counts as preamble or SFD
  assign is_pre  = !er && (rxd == PREAMBLE_BYTE);
  assign is_sfd  = !er && (rxd == SFD_BYTE);
  assign full    = cnt_q >= LEN_DLY;
  assign oldest  = dly_q[DLY_DEPTH-1];
  assign bad_eof = (crc_q != CRC32_RESIDUE)
                 | err_q
                 | (cnt_q < LEN_MIN);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    dly_d     = dly_q;
    tdata_d   = tdata_q;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;

    unique case (state_q)
      WAIT_GAP: begin
        if (!dv) state_d = IDLE;
      end

      IDLE: begin
        if (dv) begin
          if (is_pre) begin
            state_d   = PREAMBLE;
            pre_cnt_d = pre_t'(1);
          end else begin
            state_d = WAIT_GAP;
          end
        end
      end

      PREAMBLE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (is_sfd) begin
          state_d = PAYLOAD;
          crc_d   = CRC32_INIT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (is_pre && pre_cnt_q < PRE_MAX) begin
          pre_cnt_d = pre_cnt_q + pre_t'(1);
        end else begin
          state_d = WAIT_GAP;
        end
      end

      PAYLOAD: begin
        if (!dv) begin
          state_d = IDLE;
          if (full) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = oldest;
            tuser_d  = bad_eof;
          end
        end else if (cnt_q == LEN_MAX) begin
          // overlength: close the frame now, drop the rest
          state_d  = WAIT_GAP;
          cnt_d    = LEN_MAX + cnt_t'(1);
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tuser_d  = 1'b1;
          tdata_d  = oldest;
        end else begin
          crc_d = crc_nxt;
          dly_d = {dly_q[DLY_DEPTH-2:0], rxd};
          cnt_d = cnt_q + cnt_t'(1);
          err_d = err_q | er;
          if (full) begin
            tvalid_d = 1'b1;
            tdata_d  = oldest;
          end
        end
      end
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_GAP;
      pre_cnt_q <= '0;
      crc_q     <= CRC32_INIT;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      dly_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dly_q     <= dly_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
    end
  end

  assign m.m_tdata  = tdata_q;
  assign m.m_tvalid = tvalid_q;
  assign m.m_tlast  = tlast_q;
  assign m.m_tuser  = tuser_q;

`ifdef GMII_RX_FRAMER_STATS_EN
  logic [31:0] stat_ok_q, stat_ok_d;
  logic [31:0] stat_bad_q, stat_bad_d;
  logic        runt;

  // frames too short to expose any data byte are dropped silently
  assign runt = (state_q == PAYLOAD) && !dv && !full;

  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_bad_d = stat_bad_q;
    if (tlast_d && !tuser_d) begin
      stat_ok_d = stat_ok_q + 32'd1;
    end
    if ((tlast_d && tuser_d) || runt) begin
      stat_bad_d = stat_bad_q + 32'd1;
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q  <= '0;
      stat_bad_q <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_bad_q <= stat_bad_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_bad = stat_bad_q;
`else
  assign stat_ok  = '0;
  assign stat_bad = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized bench for gmii_rx_framer against a frame-level model.
// Expected beats come from frame length, preamble and error rules.
module tb_gmii_rx_framer;

  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;
  localparam int MAX_PRE = 7;

`ifdef GMII_RX_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stat_ok;
  logic [31:0] stat_bad;

  gmii_rx_if        g ();
  gmii_rx_stream_if s ();

  gmii_rx_framer #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN),
    .MAX_PRE (MAX_PRE)
  ) dut (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .gmii        (g),
    .m           (s),
    .stat_ok     (stat_ok),
    .stat_bad    (stat_bad)
  );

  always #4 clk = ~clk;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    ok_exp = 0;
  int    bad_exp = 0;

  always @(negedge clk) begin
    if (rst_n && s.m_tvalid) begin
      got_q.push_back({s.m_tdata, s.m_tlast, s.m_tuser});
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fcs32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // n bytes DA..FCS; corrupt flips one payload bit after the FCS is made
  function automatic bq_t mk_frame(input int n, input bit corrupt);
    bq_t         f;
    logic [31:0] fcs;
    int          idx;
    if (n < 4) begin
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      return f;
    end
    for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
    fcs = fcs32(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    if (corrupt && n > 4) begin
      idx = $urandom_range(0, n - 5);
      f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
    end
    return f;
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv,
                       input logic er);
    @(negedge clk);
    g.gmii_rxd   = d;
    g.gmii_rx_dv = dv;
    g.gmii_rx_er = er;
  endtask

  function automatic void model(input bq_t f, input int npre,
                                input bit bad);
    int n;
    int l;
    bit u;
    n = f.size();
    if (npre < 1 || npre > MAX_PRE) return;
    if (n < 5) begin
      bad_exp++;
      return;
    end
    l = (n > MAX_LEN) ? MAX_LEN - 4 : n - 4;
    u = bad || (n > MAX_LEN) || (n < MIN_LEN);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({f[i], (i == l - 1), u});
    end
    if (u) bad_exp++;
    else ok_exp++;
  endfunction

  task automatic run(input bq_t f, input int npre, input bit bad,
                     input int er_at, input int gap);
    model(f, npre, bad || (er_at >= 0 && er_at < f.size()));
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (f[i]) drive(f[i], 1'b1, (i == er_at));
    for (int i = 0; i < gap; i++) drive(8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic flush(input string tag);
    int n;
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
      chk({tag, "_last"}, 32'(got_q[i].last), 32'(exp_q[i].last));
      if (exp_q[i].last) begin
        chk({tag, "_user"}, 32'(got_q[i].user), 32'(exp_q[i].user));
      end
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, "_stat_ok"}, stat_ok, STATS ? 32'(ok_exp) : 32'd0);
    chk({tag, "_stat_bad"}, stat_bad, STATS ? 32'(bad_exp) : 32'd0);
  endtask

  initial begin
    int n;
    int npre;
    int er_at;
    bit bad;

    g.gmii_rxd   = 8'h00;
    g.gmii_rx_dv = 1'b0;
    g.gmii_rx_er = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(s.m_tvalid), 32'd0);
    chk("rst_tlast", 32'(s.m_tlast), 32'd0);
    chk("rst_tuser", 32'(s.m_tuser), 32'd0);
    chk("rst_tdata", 32'(s.m_tdata), 32'd0);
    chk("rst_stat_ok", stat_ok, 32'd0);
    chk("rst_stat_bad", stat_bad, 32'd0);

    // leave reset in the middle of foreign traffic
    g.gmii_rxd   = 8'h55;
    g.gmii_rx_dv = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive((i % 3 == 0) ? 8'h55 : 8'($urandom), 1'b1, 1'b0);
    end
    drive(8'h00, 1'b0, 1'b0);
    run(mk_frame(64, 1'b0), 7, 1'b0, -1, 1);
    flush("resync");

    run(mk_frame(64, 1'b0), 7, 1'b0, -1, 2);
    flush("good64");
    run(mk_frame(64, 1'b1), 7, 1'b1, -1, 2);
    flush("crcbad");
    run(mk_frame(40, 1'b0), 3, 1'b0, -1, 2);
    flush("runt40");
    run(mk_frame(3, 1'b0), 7, 1'b0, -1, 2);
    flush("tiny3");
    run(mk_frame(5, 1'b0), 1, 1'b0, -1, 1);
    flush("min5");
    run(mk_frame(MAX_LEN + 10, 1'b0), 7, 1'b0, -1, 1);
    flush("overlen");
    run(mk_frame(MAX_LEN, 1'b0), 7, 1'b0, -1, 1);
    flush("maxlen");
    run(mk_frame(80, 1'b0), 7, 1'b0, 20, 2);
    flush("er20");
    run(mk_frame(64, 1'b0), 7, 1'b0, -1, 1);
    run(mk_frame(70, 1'b0), 7, 1'b0, -1, 1);
    flush("b2b");
    run(mk_frame(64, 1'b0), 8, 1'b0, -1, 1);
    run(mk_frame(64, 1'b0), 0, 1'b0, -1, 1);
    run(mk_frame(66, 1'b0), 2, 1'b0, -1, 1);
    flush("badpre");

    for (int t = 0; t < 30; t++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_LEN - 2, MAX_LEN + 4)
                                      : $urandom_range(1, 100);
      npre  = $urandom_range(0, 8);
      bad   = ($urandom_range(0, 3) == 0) && (n > 4);
      er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      run(mk_frame(n, bad), npre, bad, er_at, $urandom_range(1, 3));
      if (t % 3 == 2) flush("rand");
    end
    flush("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
- Consumes the raw GMII byte stream (rxd, dv, er) produced by the RGMII-to-GMII adapter in the 125 MHz recovered-clock domain.
- Strips the preamble and SFD, checks CRC-32, removes the 4-byte FCS and enforces length limits.
- Emits a per-byte valid/last/error stream to the market-data parser inside the trading core.
- There is no backpressure: the output runs at line rate.

Parameters:
- MAX_LEN, 1522: maximum frame length in bytes, DA through FCS inclusive.
- MIN_LEN, 64: minimum frame length in bytes, DA through FCS inclusive.
- MAX_PRE, 7: maximum number of 0x55 preamble bytes accepted before the SFD.

Ports:
- gmii_rx_clk  in  1  125 MHz receive clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- gmii_rxd  in  8  received byte.
- gmii_rx_dv  in  1  data valid.
- gmii_rx_er  in  1  receive error.
- m_tdata  out  8  frame byte, starting at the DA; FCS is never output.
- m_tvalid  out  1  m_tdata valid this cycle.
- m_tlast  out  1  last byte of the frame.
- m_tuser  out  1  frame bad; meaningful only when m_tlast=1.
- stat_ok  out  32  count of good frames.
- stat_bad  out  32  count of bad or aborted frames.

Behaviour:
- Clock and reset: one clock, gmii_rx_clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state WAIT_GAP; CRC register 0xFFFFFFFF; byte count 0; error flag 0.
- All outputs are registered.
- WAIT_GAP:
  - Entered on reset, on an overlength frame, or after a malformed preamble.
  - Leaves to IDLE only after a cycle with dv=0, so the block never locks onto the middle of a frame.
- IDLE:
  - dv=1 and rxd=0x55: go to PREAMBLE with pre_cnt=1.
  - dv=1 with any other byte: go to WAIT_GAP.
- PREAMBLE:
  - rxd=0x55 and pre_cnt<MAX_PRE: pre_cnt++.
  - rxd=0xD5: go to PAYLOAD; clear CRC register, byte count and error flag.
  - Any other byte, or more than MAX_PRE preamble bytes: go to WAIT_GAP; no output.
  - dv=0: go to IDLE; no output.
- PAYLOAD:
  - Each dv=1 byte enters the CRC (reflected polynomial 0xEDB88320, one byte per clock).
  - Each byte is pushed into a 5-deep delay line; byte count increments, saturating at MAX_LEN+1.
  - When the delay line is full, each push emits its oldest entry with m_tvalid=1, m_tlast=0.
  - Byte k (0 = first DA byte) therefore appears 1 cycle after byte k+5 is sampled.
  - er=1 on any dv=1 cycle sets the error flag.
- End of frame (dv falls while in PAYLOAD):
  - If count ≥5: the next cycle emits the oldest delay-line entry (the last data byte) with m_tlast=1. The 4 FCS bytes are discarded.
  - m_tuser = (CRC register ≠ 0xDEBB20E3) | error flag | (count < MIN_LEN).
  - If count <5: nothing is emitted, the frame is counted bad, and the state returns to IDLE.
- Overlength: when the count would exceed MAX_LEN while dv=1, emit the oldest entry with m_tlast=1 and m_tuser=1 that cycle, then go to WAIT_GAP.
- dv=1 with er=1 in IDLE or PREAMBLE is treated as a non-preamble byte.
- Back-to-back frames with a one-cycle dv gap are supported: the tlast cycle coincides with the first IDLE cycle.
- Reset asserted mid-frame: the output is truncated with no tlast, and WAIT_GAP discards the rest of the frame.

Optional Feature:
- Macro: GMII_RX_FRAMER_STATS_EN.
- Defined:
  - stat_ok increments on tlast with tuser=0.
  - stat_bad increments on tlast with tuser=1 and on runt (<5 byte) drops.
  - Both counters are 32-bit and wrap.
- Undefined: stat_ok and stat_bad are tied to 0 and no counter logic is built.

Decomposition:
- Package gmii_rx_pkg holds:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
  - The state enum {WAIT_GAP, IDLE, PREAMBLE, PAYLOAD}.
- Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]).

Test Plan:
- 64-byte frame after 7×0x55 + 0xD5 with correct FCS → 60 bytes out, matching the input DA.., tlast on byte 60, tuser=0, stat_ok=1.
- Same frame with one payload bit flipped → 60 bytes out, tlast tuser=1, stat_bad=1.
- dv asserted after reset mid-frame (no preamble), then a valid frame after a 1-cycle gap → first frame ignored, second frame delivered cleanly.
- 40-byte frame with valid CRC → 36 bytes out, tuser=1 (runt); a 3-byte frame → no output, stat_bad+1.
- Frame of MAX_LEN+10 bytes → tlast with tuser=1 at byte MAX_LEN-4 position; nothing further until dv drops; the next frame is good.
- er=1 on byte 20 of a valid-CRC frame → tuser=1; two back-to-back good frames with a 1-cycle gap → both delivered, stat_ok=2.
